// File: rtl/spi_msg_pkg.sv
// spi_msg_pkg: shared types and constants for the SPI message sequencer.
// Holds the FSM state enum, the message byte table, the default message
// length and small elaboration-time helpers.
package spi_msg_pkg;

  localparam int DEFAULT_DATA_LENGTH = 14;
  localparam int MSG_ROM_LEN         = 14;

  // "Hello World!\r\n", byte 0 first
  localparam logic [0:MSG_ROM_LEN-1][7:0] MSG_ROM = {
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
    8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  // Message byte lookup; positions beyond the table read as zero so a
  // larger DATA_LENGTH never indexes outside the table.
  function automatic logic [7:0] msg_byte(input int idx);
    if (idx >= 0 && idx < MSG_ROM_LEN) return MSG_ROM[idx];
    return 8'h00;
  endfunction

  // XOR of the first len message bytes (checksum byte value)
  function automatic logic [7:0] msg_xor(input int len);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < len; i++) acc = acc ^ msg_byte(i);
    return acc;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than 1 bit
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_wait_timer.sv
// spi_wait_timer: counts the idle gap between frames.
// While start is held high the counter runs 0..WAIT_TICKS-1; done is high
// on the final count, so start held for a whole gap gives exactly
// WAIT_TICKS cycles. Dropping start returns the counter to zero.
// WAIT_TICKS must be at least 1.
module spi_wait_timer
  import spi_msg_pkg::*;
#(
  parameter int WAIT_TICKS = 19200
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int              CW   = clog2_min1(WAIT_TICKS);
  localparam logic [CW-1:0]   LAST = CW'(WAIT_TICKS - 1);

  logic [CW-1:0] cnt;

  assign done = start && (cnt == LAST);

  // Count while started; clear on reset, when idle, or at the final tick
  always_ff @(posedge clk) begin
    if (rst || !start || done) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/spi_msg_sequencer.sv
// spi_msg_sequencer: repeatedly offers a fixed ASCII message to a
// downstream SPI transmitter over a valid/ready byte stream, with an idle
// gap of WAIT_TICKS cycles between frames and a count of completed frames.
// Optional build macro SPI_MSG_CHECKSUM_EN appends an XOR checksum byte.
module spi_msg_sequencer
  import spi_msg_pkg::*;
#(
  parameter int WAIT_TICKS  = 19200,
  parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic [15:0] msg_count
);

`ifdef SPI_MSG_CHECKSUM_EN
  localparam int         FRAME_LEN = DATA_LENGTH + 1;
  localparam logic [7:0] CSUM      = msg_xor(DATA_LENGTH);
`else
  localparam int         FRAME_LEN = DATA_LENGTH;
`endif

  localparam int               IDX_W    = clog2_min1(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n, idx_inc;
  logic [7:0]        data_n;
  logic              valid_n, last_n;
  logic [15:0]       count_n;
  logic              wait_start, wait_done;
  logic              hs;

  // Byte at frame position i (checksum occupies position DATA_LENGTH)
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] i);
`ifdef SPI_MSG_CHECKSUM_EN
    if (int'(i) == DATA_LENGTH) return CSUM;
`endif
    return msg_byte(int'(i));
  endfunction

  assign hs         = tx_valid && tx_ready;
  assign idx_inc    = idx + 1'b1;
  assign busy       = (state != S_IDLE);
  assign wait_start = (state == S_WAIT);

  spi_wait_timer #(
    .WAIT_TICKS (WAIT_TICKS)
  ) u_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .start (wait_start),
    .done  (wait_done)
  );

  // Next-state and next-output decode; everything holds unless changed
  always_comb begin
    state_n = state;
    idx_n   = idx;
    data_n  = tx_data;
    valid_n = tx_valid;
    last_n  = tx_last;
    count_n = msg_count;
    case (state)
      S_IDLE: begin
        if (enable) state_n = S_LOAD;
      end
      S_LOAD: begin
        idx_n   = '0;
        data_n  = frame_byte('0);
        valid_n = 1'b1;
        last_n  = (LAST_IDX == '0);
        state_n = S_SEND;
      end
      S_SEND: begin
        // enable is not consulted here: a started frame always completes
        if (hs) begin
          if (idx == LAST_IDX) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            idx_n   = '0;
            count_n = msg_count + 16'd1;
            state_n = S_WAIT;
          end else begin
            idx_n  = idx_inc;
            data_n = frame_byte(idx_inc);
            last_n = (idx_inc == LAST_IDX);
          end
        end
      end
      S_WAIT: begin
        // enable only matters on the last tick of the gap
        if (wait_done) state_n = enable ? S_LOAD : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered stream outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      tx_last   <= 1'b0;
      msg_count <= 16'h0000;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      tx_data   <= data_n;
      tx_valid  <= valid_n;
      tx_last   <= last_n;
      msg_count <= count_n;
    end
  end

endmodule

// File: tb/tb_spi_msg_sequencer.sv
// tb_spi_msg_sequencer: scoreboard bench. Stimulus pushes expected frame
// bytes into a queue; a negedge monitor pops and compares on each
// handshake and checks that an offered byte holds until accepted.
module tb_spi_msg_sequencer;

  localparam int WT = 19200;
`ifdef SPI_MSG_CHECKSUM_EN
  localparam int FL = 15;
`else
  localparam int FL = 14;
`endif

  localparam logic [7:0] EXP_BYTES [0:14] = '{
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57, 8'h6F,
    8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A, 8'h06
  };

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, enable, tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last, busy;
  logic [15:0] msg_count;

  exp_t exp_q[$];
  int   n_vec = 0, n_err = 0;
  int   hs_in_frame = 0, frames_done = 0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  spi_msg_sequencer #(
    .WAIT_TICKS  (WT),
    .DATA_LENGTH (14)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_last   (tx_last),
    .busy      (busy),
    .msg_count (msg_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) tx_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < FL; i++) begin
      e.data = EXP_BYTES[i];
      e.last = (i == FL - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_frame_done(input string name, input int bound, output int cycles);
    int start;
    start  = frames_done;
    cycles = 0;
    while (frames_done == start && cycles < bound) begin
      step();
      cycles++;
    end
    if (frames_done == start) fail_timeout(name);
  endtask

  task automatic wait_hs(input string name, input int target, input int bound);
    int n;
    n = 0;
    while (hs_in_frame < target && n < bound) begin
      step();
      n++;
    end
    if (hs_in_frame < target) fail_timeout(name);
  endtask

  // Monitor: stability of offered bytes and in-order scoreboard on handshakes
  initial begin
    exp_t       e;
    logic       p_valid, p_ready, p_last;
    logic [7:0] p_data;
    bit         p_rst;
    p_valid = 1'b0; p_ready = 1'b0; p_last = 1'b0; p_data = 8'h00; p_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs_in_frame = 0;
      end else begin
        if (!p_rst && p_valid && !p_ready) begin
          chk("hold_valid", 32'(tx_valid), 32'd1);
          chk("hold_data",  32'(tx_data),  32'(p_data));
          chk("hold_last",  32'(tx_last),  32'(p_last));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_byte: got %0h, expected no byte", tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("byte", 32'(tx_data), 32'(e.data));
            chk("last", 32'(tx_last), 32'(e.last));
            hs_in_frame++;
            if (e.last) begin
              hs_in_frame = 0;
              frames_done++;
            end
          end
        end
      end
      p_valid = tx_valid; p_ready = tx_ready; p_data = tx_data; p_last = tx_last; p_rst = rst;
    end
  end

  // Stimulus
  initial begin
    int cyc, gap, n;
    rst = 1'b1; enable = 1'b0; tx_ready = 1'b0;
    repeat (3) step();
    chk("rst_valid", 32'(tx_valid),  32'd0);
    chk("rst_last",  32'(tx_last),   32'd0);
    chk("rst_data",  32'(tx_data),   32'h00);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_count", 32'(msg_count), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Frame 1: ready always high, back-to-back bytes
    push_frame();
    enable = 1'b1; tx_ready = 1'b1;
    step();
    chk("load_busy",  32'(busy),     32'd1);
    chk("load_valid", 32'(tx_valid), 32'd0);
    step();
    chk("first_valid", 32'(tx_valid), 32'd1);
    chk("first_data",  32'(tx_data),  32'h48);
    wait_frame_done("frame1", 100, cyc);
    chk("throughput", 32'(cyc), 32'(FL));
    chk("count_1",    32'(msg_count), 32'd1);
    chk("drop_valid", 32'(tx_valid),  32'd0);
    chk("wait_busy",  32'(busy),      32'd1);
    push_frame();

    // Preload the counter during the gap so frame 2 wraps it
    gap = 0;
    force dut.msg_count = 16'hFFFF;
    step();
    gap++;
    release dut.msg_count;
    chk("count_preload", 32'(msg_count), 32'hFFFF);
    while (!tx_valid && gap < WT + 100) begin
      step();
      gap++;
    end
    if (!tx_valid) fail_timeout("gap");
    // WAIT_TICKS idle cycles plus the one LOAD cycle
    chk("gap_cycles", 32'(gap), 32'(WT + 1));
    chk("gap_data",   32'(tx_data), 32'h48);

    // Frame 2: random ready, enable dropped after byte 5
    rand_ready = 1'b1;
    wait_hs("byte5", 6, 500);
    enable = 1'b0;
    wait_frame_done("frame2", 500, cyc);
    chk("count_wrap", 32'(msg_count), 32'd0);
    rand_ready = 1'b0; tx_ready = 1'b1;
    n = 0;
    while (busy && n < WT + 100) begin
      step();
      n++;
    end
    chk("wait_len",   32'(n), 32'(WT));
    repeat (5) step();
    chk("idle_after", 32'(busy),     32'd0);
    chk("idle_valid", 32'(tx_valid), 32'd0);

    // Frame 3: reset while byte 7 is offered, then restart
    push_frame();
    enable = 1'b1;
    wait_hs("byte7", 7, 100);
    chk("byte7_data", 32'(tx_data), 32'h6F);
    rst = 1'b1;
    exp_q.delete();
    step();
    chk("abort_valid", 32'(tx_valid),  32'd0);
    chk("abort_count", 32'(msg_count), 32'd0);
    chk("abort_busy",  32'(busy),      32'd0);
    chk("abort_last",  32'(tx_last),   32'd0);
    rst = 1'b0;
    push_frame();
    step();
    step();
    chk("restart_valid", 32'(tx_valid), 32'd1);
    chk("restart_data",  32'(tx_data),  32'h48);
    wait_frame_done("frame3", 100, cyc);
    chk("count_restart", 32'(msg_count), 32'd1);
    enable = 1'b0;
    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_msg_sequencer.md
SPI_MSG_SEQUENCER -- requirements
Module: spi_msg_sequencer

Interface
REQ-001 The block SHALL have parameter WAIT_TICKS, default 19200, the number of idle clk cycles between messages.
REQ-002 The block SHALL have parameter DATA_LENGTH, default 14, the message length in bytes.
REQ-003 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: when high, messages are sent repeatedly.
REQ-007 The block SHALL have port tx_data, output, 8 bits, the byte offered to the downstream SPI transmitter.
REQ-008 The block SHALL have port tx_valid, output, 1 bit, meaning tx_data is valid.
REQ-009 The block SHALL have port tx_ready, input, 1 bit, meaning the SPI transmitter accepts the byte this cycle.
REQ-010 The block SHALL have port tx_last, output, 1 bit, which marks the final byte of a frame.
REQ-011 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-012 The block SHALL have port msg_count, output, 16 bits, the number of completed frames.

Function
REQ-013 The message SHALL be the ASCII string "Hello World!\r\n" (0x48 65 6C 6C 6F 20 57 6F 72 6C 64 21 0D 0A), indexed 0..DATA_LENGTH-1.
REQ-014 The FSM SHALL have the states IDLE, LOAD, SEND and WAIT.
REQ-015 In IDLE with enable high at a rising edge, the FSM SHALL go to LOAD; otherwise it SHALL remain in IDLE.
REQ-016 LOAD SHALL register byte 0 into tx_data and go to SEND in one cycle, so tx_valid rises 2 edges after enable is sampled.
REQ-017 In SEND, tx_valid SHALL be high, and a handshake SHALL occur only on a cycle where tx_valid and tx_ready are both high.
REQ-018 Without a handshake, tx_data, tx_valid and tx_last SHALL hold stable; tx_valid SHALL never drop before its handshake.
REQ-019 On a non-final handshake, the byte index SHALL increment and tx_data SHALL update on the same edge, giving back-to-back throughput of 1 byte per cycle.
REQ-020 tx_last SHALL be high exactly while the final frame byte is offered.
REQ-021 On the final handshake, msg_count SHALL increment, tx_valid SHALL drop next cycle, and the FSM SHALL go to WAIT.
REQ-022 msg_count SHALL wrap from 16'hFFFF to 0.
REQ-023 WAIT SHALL last exactly WAIT_TICKS cycles, using a counter from 0 to WAIT_TICKS-1.
REQ-024 On leaving WAIT, the FSM SHALL go to LOAD if enable is high, else to IDLE.
REQ-025 Deasserting enable in LOAD or SEND SHALL NOT abort the frame; the frame completes, then WAIT runs, then the FSM goes to IDLE.
REQ-026 enable SHALL be ignored inside WAIT except at its final cycle.
REQ-027 The byte index and the WAIT counter SHALL be sized to $clog2 of their maximum value, with a minimum of 1 bit, and SHALL never index past the frame length.

Reset
REQ-028 While rst is high, the block SHALL hold state=IDLE, tx_valid=0, tx_last=0, tx_data=8'h00, busy=0, msg_count=0, byte index=0, and WAIT counter=0.
REQ-029 rst asserted mid-frame or mid-WAIT SHALL abort on the next edge with no further handshake, and msg_count SHALL clear.

Configuration
REQ-030 With macro SPI_MSG_CHECKSUM_EN defined, a checksum byte SHALL be appended, equal to the XOR of all message bytes (0x06 for the default message).
REQ-031 With SPI_MSG_CHECKSUM_EN defined, the frame SHALL be DATA_LENGTH+1 bytes, and tx_last SHALL be on the checksum byte.
REQ-032 Without SPI_MSG_CHECKSUM_EN, the frame SHALL be DATA_LENGTH bytes, tx_last SHALL be on byte DATA_LENGTH-1, and no checksum logic SHALL exist.

Structure
REQ-033 Package spi_msg_pkg SHALL hold the state enum type, the message byte-array constant and the default DATA_LENGTH.
REQ-034 The WAIT counter SHALL be a sub-module spi_wait_timer (inputs start, WAIT_TICKS parameter; output done) instantiated once.

Verification
REQ-035 The bench SHALL drive enable=1 with tx_ready=1 and check 14 consecutive bytes 0x48..0x0A, tx_last on 0x0A, msg_count=1, and a gap of 19200 cycles before the next 0x48.
REQ-036 The bench SHALL toggle tx_ready with a random 50% pattern and check that tx_data and tx_valid are stable whenever tx_ready=0 and that the byte order is unchanged.
REQ-037 The bench SHALL drop enable after byte 5 and check that the frame finishes with all 14 bytes, WAIT runs, then the FSM is IDLE with busy=0.
REQ-038 The bench SHALL assert rst during byte 7 and check tx_valid=0 and msg_count=0 the next cycle, and that a restart begins at 0x48.
REQ-039 The bench SHALL build with SPI_MSG_CHECKSUM_EN and check 15 bytes, the last being 0x06 with tx_last high.
REQ-040 The bench SHALL force msg_count to 16'hFFFF and complete a frame, then check that msg_count=0.
